// File: rtl/sb_tx_pkg.sv
// Shared types and packet layout for the sideband TX message engine.
package sb_tx_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_RSP = 2'd2} fsm_e;
  typedef enum logic {SRC_LTSM = 1'b0, SRC_RDI = 1'b1} src_e;

  localparam int unsigned INFO_W  = 3;
  localparam int unsigned NO_W    = 4;
  localparam int unsigned SUB_W   = 4;
  localparam int unsigned STATE_W = 3;
  // Message header width including rsp_req (not transmitted)
  localparam int unsigned HDR_W   = 1 + STATE_W + SUB_W + NO_W + INFO_W;

  // Header field offsets above the data field in the packet
  localparam int unsigned INFO_OFF  = 0;
  localparam int unsigned NO_OFF    = INFO_OFF + INFO_W;
  localparam int unsigned SUB_OFF   = NO_OFF + NO_W;
  localparam int unsigned STATE_OFF = SUB_OFF + SUB_W;
  localparam int unsigned SRC_OFF   = STATE_OFF + STATE_W;

  typedef struct packed {
    logic               rsp_req;
    logic [STATE_W-1:0] state;
    logic [SUB_W-1:0]   sub_state;
    logic [NO_W-1:0]    msg_no;
    logic [INFO_W-1:0]  msg_info;
  } msg_hdr_t;

  function automatic logic ctrl_parity(input msg_hdr_t hdr, input src_e src);
    return ^{src, hdr.state, hdr.sub_state, hdr.msg_no, hdr.msg_info};
  endfunction

endpackage

// File: rtl/sb_tx_msg_engine_fifo.sv
// Registered synchronous FIFO; clear takes priority over pop, a push in the
// clear cycle survives, and push+pop is allowed while full.
module sb_sync_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    o_full  = (count == LW'(DEPTH));
    o_empty = (count == '0);
    pop_ok  = i_pop && !o_empty && !i_clr;
    push_ok = i_push && (i_clr || !o_full || pop_ok);
  end

  assign o_rdata = mem[rd_ptr];
  assign o_level = count;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (i_clr) begin
        rd_ptr <= wr_ptr;
        count  <= push_ok ? LW'(1) : '0;
      end else begin
        if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + LW'(1);
          2'b01:   count <= count - LW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/sb_tx_msg_engine.sv
// Sideband TX message engine: round-robin LTSM/RDI intake, queue, packer and
// response tracking. Optional packet parity bits: define SB_TX_PARITY_EN.
module sb_tx_msg_engine
  import sb_tx_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned PKT_W       = 64,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 8000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ltsm_valid,
  output logic                       o_ltsm_ready,
  input  logic [DATA_W+14:0]         i_ltsm_msg,
  input  logic                       i_rdi_valid,
  output logic                       o_rdi_ready,
  input  logic [DATA_W+14:0]         i_rdi_msg,
  input  logic                       i_flush,
  input  logic                       i_stop_cnt,
  input  logic                       i_ser_done,
  input  logic                       i_rsp_rcvd,
  output logic                       o_pkt_valid,
  output logic [PKT_W-1:0]           o_pkt,
  output logic                       o_time_out,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int unsigned MSG_W = DATA_W + HDR_W;
  localparam int unsigned ENT_W = MSG_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  fsm_e             state_q;
  src_e             rr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_req_q;

  logic             grant_l;
  logic             grant_r;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             clr;
  logic             to_hit;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] rdata;
  msg_hdr_t         rd_hdr;
  src_e             rd_src;
  logic [DATA_W-1:0] rd_data;
  logic [PKT_W-1:0] pkt_c;

  // Round-robin arbiter: a lone requester wins, otherwise the pointer decides
  always_comb begin
    grant_l      = i_ltsm_valid && (!i_rdi_valid || (rr_q == SRC_LTSM));
    grant_r      = i_rdi_valid && (!i_ltsm_valid || (rr_q == SRC_RDI));
    o_ltsm_ready = grant_l && !full && !i_flush;
    o_rdi_ready  = grant_r && !full && !i_flush;
    push         = o_ltsm_ready || o_rdi_ready;
    wdata        = grant_r ? {SRC_RDI, i_rdi_msg} : {SRC_LTSM, i_ltsm_msg};
  end

  always_comb begin
    pop    = (state_q == IDLE) && !empty && !i_flush;
    to_hit = (state_q == WAIT_RSP) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) &&
             !i_rsp_rcvd && !i_stop_cnt && !i_flush;
    clr    = i_flush || to_hit;
  end

  sb_sync_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (clr),
    .i_push  (push),
    .i_wdata (wdata),
    .i_pop   (pop),
    .o_rdata (rdata),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_level)
  );

  // Packer: data at the bottom, header fields above, parity in the top two bits
  always_comb begin
    rd_data = rdata[DATA_W-1:0];
    rd_hdr  = msg_hdr_t'(rdata[DATA_W +: HDR_W]);
    rd_src  = src_e'(rdata[ENT_W-1]);
    pkt_c   = '0;
    pkt_c[DATA_W-1:0]                  = rd_data;
    pkt_c[DATA_W + INFO_OFF  +: INFO_W]  = rd_hdr.msg_info;
    pkt_c[DATA_W + NO_OFF    +: NO_W]    = rd_hdr.msg_no;
    pkt_c[DATA_W + SUB_OFF   +: SUB_W]   = rd_hdr.sub_state;
    pkt_c[DATA_W + STATE_OFF +: STATE_W] = rd_hdr.state;
    pkt_c[DATA_W + SRC_OFF]              = rd_src;
`ifdef SB_TX_PARITY_EN
    pkt_c[PKT_W-1] = ^rd_data;
    pkt_c[PKT_W-2] = ctrl_parity(rd_hdr, rd_src);
`endif
  end

  assign o_busy = (state_q != IDLE) || !empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rr_q        <= SRC_LTSM;
      cnt_q       <= '0;
      rsp_req_q   <= 1'b0;
      o_pkt_valid <= 1'b0;
      o_pkt       <= '0;
      o_time_out  <= 1'b0;
    end else begin
      o_time_out <= 1'b0;
      if (push) rr_q <= (rr_q == SRC_LTSM) ? SRC_RDI : SRC_LTSM;
      if (i_flush) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        o_pkt_valid <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (pop) begin
              o_pkt       <= pkt_c;
              o_pkt_valid <= 1'b1;
              rsp_req_q   <= rd_hdr.rsp_req;
              state_q     <= SEND;
            end
          end
          SEND: begin
            if (i_ser_done) begin
              o_pkt_valid <= 1'b0;
              cnt_q       <= '0;
              state_q     <= rsp_req_q ? WAIT_RSP : IDLE;
            end
          end
          WAIT_RSP: begin
            // A response on the terminal cycle beats the timeout
            if (i_rsp_rcvd) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else if (to_hit) begin
              o_time_out <= 1'b1;
              cnt_q      <= '0;
              state_q    <= IDLE;
            end else if (!i_stop_cnt) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sb_tx_msg_engine.sv
// Self-checking bench for sb_tx_msg_engine: directed scenarios plus a random
// phase, all compared against a transaction-level queue model.
module tb_sb_tx_msg_engine;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned PKT_W       = 64;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned TIMEOUT_CYC = 8000;

  logic        i_clk;
  logic        i_rst;
  logic        i_ltsm_valid;
  logic        o_ltsm_ready;
  logic [30:0] i_ltsm_msg;
  logic        i_rdi_valid;
  logic        o_rdi_ready;
  logic [30:0] i_rdi_msg;
  logic        i_flush;
  logic        i_stop_cnt;
  logic        i_ser_done;
  logic        i_rsp_rcvd;
  logic        o_pkt_valid;
  logic [63:0] o_pkt;
  logic        o_time_out;
  logic        o_busy;
  logic [2:0]  o_level;

  sb_tx_msg_engine #(
    .DATA_W      (DATA_W),
    .PKT_W       (PKT_W),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ltsm_valid (i_ltsm_valid),
    .o_ltsm_ready (o_ltsm_ready),
    .i_ltsm_msg   (i_ltsm_msg),
    .i_rdi_valid  (i_rdi_valid),
    .o_rdi_ready  (o_rdi_ready),
    .i_rdi_msg    (i_rdi_msg),
    .i_flush      (i_flush),
    .i_stop_cnt   (i_stop_cnt),
    .i_ser_done   (i_ser_done),
    .i_rsp_rcvd   (i_rsp_rcvd),
    .o_pkt_valid  (o_pkt_valid),
    .o_pkt        (o_pkt),
    .o_time_out   (o_time_out),
    .o_busy       (o_busy),
    .o_level      (o_level)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected queue of {src, msg}, plus engine phase flags
  logic [31:0] exp_q[$];
  int          mcount;
  bit          rr;
  bit          in_send;
  bit          waiting;
  bit          cur_rsp;
  int          wait_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] mk(input bit rsp, input logic [2:0] st, input logic [3:0] sub,
                                     input logic [3:0] no, input logic [2:0] info,
                                     input logic [15:0] data);
    return {rsp, st, sub, no, info, data};
  endfunction

  // Expected packet from a queue entry {src, rsp, state, sub, no, info, data}
  function automatic logic [63:0] pack(input logic [31:0] e);
    logic [14:0] hdr;
    logic        dp;
    logic        cp;
    hdr = {e[31], e[29:16]};
`ifdef SB_TX_PARITY_EN
    dp = ^e[15:0];
    cp = ^hdr;
`else
    dp = 1'b0;
    cp = 1'b0;
`endif
    return {dp, cp, 31'd0, hdr, e[15:0]};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    mcount   = 0;
    in_send  = 1'b0;
    waiting  = 1'b0;
    wait_cnt = 0;
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs
  task automatic step(input bit lv, input logic [30:0] lm, input bit rv, input logic [30:0] rm,
                      input bit sd, input bit rsp, input bit fl, input bit stp);
    bit          gl, gr, el, er, exp_pop, exp_to;
    logic [31:0] ent;
    i_ltsm_valid = lv;
    i_ltsm_msg   = lm;
    i_rdi_valid  = rv;
    i_rdi_msg    = rm;
    i_ser_done   = sd;
    i_rsp_rcvd   = rsp;
    i_flush      = fl;
    i_stop_cnt   = stp;
    #1;
    gl = lv && (!rv || !rr);
    gr = rv && (!lv || rr);
    el = gl && (mcount < DEPTH) && !fl;
    er = gr && (mcount < DEPTH) && !fl;
    chk("ltsm_ready", 64'(o_ltsm_ready), 64'(el));
    chk("rdi_ready", 64'(o_rdi_ready), 64'(er));
    exp_pop = 1'b0;
    exp_to  = 1'b0;
    if (fl) begin
      model_clear();
    end else begin
      exp_pop = !in_send && !waiting && (mcount > 0);
      if (waiting) begin
        if (rsp) waiting = 1'b0;
        else if (wait_cnt == TIMEOUT_CYC - 1 && !stp) begin
          waiting = 1'b0;
          exp_to  = 1'b1;
          exp_q.delete();
          mcount = 0;
        end else if (!stp) wait_cnt++;
      end
      if (el || er) begin
        exp_q.push_back({er, er ? rm : lm});
        mcount++;
        rr = !rr;
      end
      if (in_send && sd) begin
        in_send = 1'b0;
        if (cur_rsp) begin
          waiting  = 1'b1;
          wait_cnt = 0;
        end
      end
    end
    @(posedge i_clk);
    #1;
    if (exp_pop) begin
      ent = exp_q.pop_front();
      mcount--;
      in_send = 1'b1;
      cur_rsp = ent[30];
      chk("pkt", o_pkt, pack(ent));
    end
    chk("pkt_valid", 64'(o_pkt_valid), 64'(in_send));
    chk("time_out", 64'(o_time_out), 64'(exp_to));
    chk("level", 64'(o_level), 64'(mcount));
    chk("busy", 64'(o_busy), 64'(in_send || waiting || (mcount > 0)));
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_l(input logic [30:0] m);
    step(1'b1, m, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ser_done_step();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_ltsm_valid = 1'b0;
    i_rdi_valid  = 1'b0;
    i_ltsm_msg   = '0;
    i_rdi_msg    = '0;
    i_flush      = 1'b0;
    i_stop_cnt   = 1'b0;
    i_ser_done   = 1'b0;
    i_rsp_rcvd   = 1'b0;
    i_rst        = 1'b1;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    chk("rst_pkt_valid", 64'(o_pkt_valid), 64'd0);
    chk("rst_pkt", o_pkt, 64'd0);
    chk("rst_time_out", 64'(o_time_out), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    i_rst = 1'b0;
    model_clear();
    rr = 1'b0;
  endtask

  initial begin
    logic [30:0] m;
    logic [30:0] r1;
    logic [30:0] r2;
    int          k;

    // Single LTSM message and latency
    do_reset();
    m = mk(1'b0, 3'd2, 4'd5, 4'h3, 3'd1, 16'hA5A5);
    push_l(m);
    chk("t1_valid_after_accept", 64'(o_pkt_valid), 64'd0);
    idle_step();
    chk("t1_valid_rise", 64'(o_pkt_valid), 64'd1);
    chk("t1_data", 64'(o_pkt[15:0]), 64'h0000_0000_0000_A5A5);
    chk("t1_src", 64'(o_pkt[30]), 64'd0);
    idle_step();
    idle_step();
    ser_done_step();
    chk("t1_idle_busy", 64'(o_busy), 64'd0);

    // Reset in the middle of a packet
    push_l(mk(1'b0, 3'd1, 4'd1, 4'd1, 3'd1, 16'h1234));
    idle_step();
    do_reset();

    // Simultaneous requests: alternating grants until the queue is full
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(1'b0, 3'd1, 4'(i), 4'd7, 3'd0, 16'h1000 + 16'(i)),
           1'b1, mk(1'b0, 3'd6, 4'(i), 4'd9, 3'd5, 16'h2000 + 16'(i)),
           1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 4) chk("t2_level_full", 64'(o_level), 64'd4);
    end
    for (int i = 0; i < 40; i++) ser_done_step();
    chk("t2_drained_busy", 64'(o_busy), 64'd0);

    // Timeout with no response, queued messages flushed
    do_reset();
    push_l(mk(1'b1, 3'd3, 4'd2, 4'd4, 3'd2, 16'hBEEF));
    push_l(mk(1'b0, 3'd0, 4'd1, 4'd1, 3'd1, 16'h0101));
    push_l(mk(1'b0, 3'd0, 4'd2, 4'd2, 3'd2, 16'h0202));
    ser_done_step();
    k = 0;
    while (!o_time_out && k < 8300) begin
      idle_step();
      k++;
    end
    chk("t3_timeout_delay", 64'(k), 64'd8000);
    chk("t3_flushed", 64'(o_level), 64'd0);
    idle_step();
    chk("t3_pulse_one_cycle", 64'(o_time_out), 64'd0);

    // Counter frozen for 100 cycles delays the timeout by 100
    push_l(mk(1'b1, 3'd4, 4'd3, 4'd5, 3'd3, 16'hCAFE));
    idle_step();
    ser_done_step();
    k = 0;
    while (!o_time_out && k < 8400) begin
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, (k >= 10) && (k < 110));
      k++;
    end
    chk("t3_stop_delay", 64'(k), 64'd8100);

    // Response on the terminal cycle wins; next message follows
    do_reset();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_l(mk(1'b1, 3'd5, 4'd6, 4'd8, 3'd4, 16'h5555));
    push_l(mk(1'b0, 3'd7, 4'd9, 4'd1, 3'd6, 16'h6666));
    ser_done_step();
    for (int i = 0; i < 8000; i++)
      step(1'b0, '0, 1'b0, '0, 1'b0, (i == 7999), 1'b0, 1'b0);
    chk("t4_no_timeout", 64'(o_time_out), 64'd0);
    idle_step();
    chk("t4_next_sent", 64'(o_pkt[15:0]), 64'h0000_0000_0000_6666);
    ser_done_step();

    // Flush in SEND with three queued
    do_reset();
    for (int i = 0; i < 4; i++) push_l(mk(1'b0, 3'd1, 4'd2, 4'd3, 3'd4, 16'h7000 + 16'(i)));
    chk("t5_queued", 64'(o_level), 64'd3);
    step(1'b1, mk(1'b0, 3'd0, 4'd0, 4'd0, 3'd0, 16'h7777), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_level", 64'(o_level), 64'd0);
    chk("t5_valid", 64'(o_pkt_valid), 64'd0);
    chk("t5_busy", 64'(o_busy), 64'd0);
    chk("t5_time_out", 64'(o_time_out), 64'd0);

    // Parity bits
    push_l(mk(1'b0, 3'd0, 4'd0, 4'd0, 3'd0, 16'h0001));
    idle_step();
`ifdef SB_TX_PARITY_EN
    chk("t6_data_parity", 64'(o_pkt[63]), 64'd1);
`else
    chk("t6_parity_bits", 64'(o_pkt[63:62]), 64'd0);
`endif
    ser_done_step();

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r1 = 31'($urandom);
      r2 = 31'($urandom);
      r1[30] = ($urandom_range(0, 3) == 0);
      r2[30] = ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 1)), r1, 1'($urandom_range(0, 1)), r2,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
